// File: rtl/dot_pe.sv
// rtl/dot_pe.sv - fixed-point dot-product PE: bias + sum(din1*din2), floor, optional ReLU, saturate
module dot_pe #(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int LEN    = 84,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int RELU   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] din1,
  input  logic signed [DATA_W-1:0] din2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     sat,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int CW = $clog2(LEN + 1);
  localparam int RW = ACC_W - FRAC;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic signed [RW-1:0] MAX_R = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic signed [OUT_W-1:0]   dout_q, dout_d;
  logic                      sat_q, sat_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [RW-1:0]       r_floor;
  logic signed [RW-1:0]       r_relu;
  logic signed [OUT_W-1:0]    res;
  logic                       res_sat;

  assign prod     = din1 * din2;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};

  // Dropping the low FRAC bits of a two's complement value is a floor, not a truncation toward zero.
  assign r_floor = acc_q[ACC_W-1:FRAC];
  assign r_relu  = (RELU != 0 && r_floor[RW-1]) ? '0 : r_floor;

  always_comb begin
    res     = r_relu[OUT_W-1:0];
    res_sat = 1'b0;
    if (r_relu > MAX_R) begin
      res     = {1'b0, {(OUT_W-1){1'b1}}};
      res_sat = 1'b1;
    end else if (r_relu < MIN_R) begin
      res     = {1'b1, {(OUT_W-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC;
          acc_d   = bias_ext;
          cnt_d   = '0;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_OUT;
        dout_d  = res;
        sat_d   = res_sat;
      end
      S_OUT: begin
        // A start on the handshake chains straight into the next run without an IDLE bubble.
        if (out_ready) begin
          if (start) begin
            state_d = S_ACC;
            acc_d   = bias_ext;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign dout      = dout_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dot_pe.sv
// tb/tb_dot_pe.sv - directed vector bench for dot_pe with LEN=4, plus ReLU instance
module tb_dot_pe;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] bias = '0;
  logic in_valid = 1'b0;
  logic signed [15:0] din1 = '0;
  logic signed [15:0] din2 = '0;
  logic out_ready = 1'b0;

  logic in_ready0, out_valid0, sat0, busy0;
  logic in_ready1, out_valid1, sat1, busy1;
  logic signed [15:0] dout0, dout1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dot_pe #(.DATA_W(16), .FRAC(8), .LEN(4), .ACC_W(40), .OUT_W(16), .RELU(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready0), .din1(din1), .din2(din2),
    .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .sat(sat0), .busy(busy0)
  );

  dot_pe #(.DATA_W(16), .FRAC(8), .LEN(4), .ACC_W(40), .OUT_W(16), .RELU(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready1), .din1(din1), .din2(din2),
    .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1), .sat(sat1), .busy(busy1)
  );

  typedef struct {
    string            name;
    logic [15:0]      bias;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [7:0]       vpat;
    int               hold;
    logic [15:0]      e_dout0;
    logic             e_sat0;
    logic [15:0]      e_dout1;
    logic             e_sat1;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [3:0][15:0] a, input logic [3:0][15:0] b, input logic [7:0] vpat);
    int beats = 0;
    int idx = 0;
    while (beats < 4 && idx < 32) begin
      in_valid = (idx < 8) ? vpat[idx] : 1'b1;
      din1 = a[beats];
      din2 = b[beats];
      tick();
      if (in_valid) beats++;
      idx++;
    end
    in_valid = 1'b0;
    check("feed_done", beats, 4);
  endtask

  task automatic wait_result(input string name);
    int lat = 1;
    check({name, "_fin_valid"}, {31'd0, out_valid0}, 0);
    tick();
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 1);
  endtask

  task automatic finish_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_valid"}, {31'd0, out_valid0}, 0);
    check({name, "_idle_busy"}, {31'd0, busy0}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1;
    bias  = v.bias;
    tick();
    start = 1'b0;
    check({v.name, "_in_ready"}, {31'd0, in_ready0}, 1);
    feed(v.a, v.b, v.vpat);
    wait_result(v.name);
    check({v.name, "_dout0"}, {16'd0, dout0}, {16'd0, v.e_dout0});
    check({v.name, "_sat0"}, {31'd0, sat0}, {31'd0, v.e_sat0});
    check({v.name, "_dout1"}, {16'd0, dout1}, {16'd0, v.e_dout1});
    check({v.name, "_sat1"}, {31'd0, sat1}, {31'd0, v.e_sat1});
    if (v.hold > 0) begin
      for (int i = 0; i < v.hold; i++) tick();
      check({v.name, "_hold_dout"}, {16'd0, dout0}, {16'd0, v.e_dout0});
      check({v.name, "_hold_sat"}, {31'd0, sat0}, {31'd0, v.e_sat0});
      check({v.name, "_hold_valid"}, {31'd0, out_valid0}, 1);
      check({v.name, "_hold_in_ready"}, {31'd0, in_ready0}, 0);
    end
    finish_out(v.name);
  endtask

  initial begin
    vecs[0] = '{"basic",  16'h0100, {4{16'h0200}}, {4{16'h0180}}, 8'hFF, 0, 16'h0D00, 1'b0, 16'h0D00, 1'b0};
    vecs[1] = '{"stall",  16'h0100, {4{16'h0200}}, {4{16'h0180}}, 8'h59, 0, 16'h0D00, 1'b0, 16'h0D00, 1'b0};
    vecs[2] = '{"ostall", 16'h0100, {4{16'h0200}}, {4{16'h0180}}, 8'hFF, 5, 16'h0D00, 1'b0, 16'h0D00, 1'b0};
    vecs[3] = '{"satpos", 16'h0000, {4{16'h7FFF}}, {4{16'h7FFF}}, 8'hFF, 0, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
    vecs[4] = '{"satneg", 16'h0000, {4{16'h8000}}, {4{16'h7FFF}}, 8'hFF, 0, 16'h8000, 1'b1, 16'h0000, 1'b0};
    vecs[5] = '{"floor",  16'h0000, {16'h0, 16'h0, 16'h0, 16'hFFFF}, {16'h0, 16'h0, 16'h0, 16'h0001},
                8'hFF, 0, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{"relu",   16'hFF00, {4{16'h0000}}, {4{16'h0000}}, 8'hFF, 0, 16'hFF00, 1'b0, 16'h0000, 1'b0};

    repeat (3) tick();
    check("rst_dout", {16'd0, dout0}, 0);
    check("rst_sat", {31'd0, sat0}, 0);
    check("rst_out_valid", {31'd0, out_valid0}, 0);
    check("rst_in_ready", {31'd0, in_ready0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // reset mid-run after two accepted beats, leaving a stale nonzero dout from the previous run
    start = 1'b1;
    bias  = 16'h0100;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    din1 = 16'h0200;
    din2 = 16'h0180;
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_busy_before", {31'd0, busy0}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy0}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready0}, 0);
    check("mid_rst_out_valid", {31'd0, out_valid0}, 0);
    check("mid_rst_dout", {16'd0, dout0}, 0);
    check("mid_rst_sat", {31'd0, sat0}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    // back-to-back: chain a second run on the output handshake, with start pulses during ACC
    start = 1'b1;
    bias  = 16'h0100;
    tick();
    start = 1'b0;
    feed({4{16'h0200}}, {4{16'h0180}}, 8'hFF);
    wait_result("b2b_first");
    check("b2b_first_dout", {16'd0, dout0}, 32'h0D00);
    start = 1'b1;
    bias  = 16'h0000;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    bias = 16'h7F00;
    check("b2b_no_idle_busy", {31'd0, busy0}, 1);
    check("b2b_in_ready", {31'd0, in_ready0}, 1);
    check("b2b_out_valid_low", {31'd0, out_valid0}, 0);
    feed({4{16'h0200}}, {4{16'h0180}}, 8'hFF);
    start = 1'b0;
    wait_result("b2b_second");
    check("b2b_second_dout", {16'd0, dout0}, 32'h0C00);
    check("b2b_second_sat", {31'd0, sat0}, 0);
    finish_out("b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_pe.md
# dot_pe

Parametrised fixed-point dot-product processing element for the fully-connected LeNet layers. It accepts `LEN` operand pairs over a valid/ready stream and accumulates their products at full precision onto a per-run bias. It then produces one rounded-down, optionally ReLU'd, saturated result on a valid/ready output port, and it supports back-to-back runs. It is instantiated once per output neuron in the FC layer arrays.

## Interface
- `DATA_W`, 16: operand/bias width, signed two's complement.
- `FRAC`, 8: fractional bits of operands, bias and output (Q(DATA_W-FRAC).FRAC).
- `LEN`, 84: operand pairs per run, at least 1.
- `ACC_W`, 40: accumulator width, at least 2*DATA_W + clog2(LEN) + 1.
- `OUT_W`, 16: result width, at most ACC_W-FRAC.
- `RELU`, 0: 1 clamps negative results to 0 before saturation.
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begins a run; sampled only in IDLE, or in OUT on the output handshake cycle.
- `bias`, in, DATA_W: sampled on the accepted `start`.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: high only in ACC.
- `din1`, `din2`, in, DATA_W each: signed operands.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `dout`, out, OUT_W: signed result.
- `sat`, out, 1: the result was clamped; qualified by `out_valid`.
- `busy`, out, 1: state is not IDLE.

## Operation
- States: IDLE, ACC, FIN, OUT.
- **IDLE:** `start` moves to ACC. On that edge, acc = sign-extended `bias` shifted left by FRAC, and count = 0.
- **ACC:**
  - Each beat with `in_valid` and `in_ready` high adds the full 2*DATA_W product `din1*din2` (sign-extended) to acc and increments count.
  - The beat where count reaches LEN-1 moves to FIN.
  - Beats with `in_valid` low change nothing.
- **FIN:** one cycle, then OUT.
  - r = acc arithmetic-right-shifted by FRAC, which floors toward minus infinity.
  - If RELU is set and r < 0, r = 0.
  - If r > 2^(OUT_W-1)-1, dout = max and sat = 1. If r < -2^(OUT_W-1), dout = min and sat = 1. Otherwise dout = r and sat = 0.
- **OUT:**
  - `out_valid` = 1. `dout` and `sat` hold stable until `out_ready` is high.
  - On the handshake, with `start` high the block goes to ACC with a new bias and a cleared acc and count. With `start` low it goes to IDLE.
- `start` in ACC or FIN is ignored. `start` in OUT without `out_ready` is ignored.
- The accumulator never wraps within ACC_W for legal parameters. Overflow is handled only by the output saturation.
- **Reset:**
  - State IDLE; acc = 0, count = 0.
  - `dout` = 0, `sat` = 0, `out_valid` = 0, `in_ready` = 0, `busy` = 0.
  - Reset mid-run discards all partial state immediately, with no output.

## Timing
- All outputs are registered or decoded directly from state. There is no combinational path from `in_valid` or `out_ready` to any output.
- `in_ready` rises the cycle after the accepted `start`.
- Latency: last beat accepted at edge k. FIN occupies k to k+1. `out_valid`, `dout` and `sat` are valid after edge k+1.
- Minimum run length is LEN+2 cycles from `start` to the output handshake. Back-to-back runs through the OUT-to-ACC path cost LEN+2 cycles per result with `in_valid` and `out_ready` held high.
- `in_ready` is 0 in FIN and OUT, so operands offered then are not consumed.

## Test plan
Tests use DATA_W=16, FRAC=8, LEN=4, ACC_W=40, OUT_W=16.

- **Basic:** bias=0x0100 (1.0), 4 beats of din1=0x0200 and din2=0x0180 (2.0×1.5) -> dout=0x0D00 (13.0), sat=0, `out_valid` two edges after the 4th beat.
- **Stalls:**
  - Same data with `in_valid` toggled 1,0,0,1,1,0,1 -> count advances only on valid beats, same 0x0D00.
  - `out_ready` held low for 5 cycles -> `dout`, `sat` and `out_valid` stay stable, `in_ready`=0.
- **Saturation and floor:**
  - 4 beats of 0x7FFF×0x7FFF -> dout=0x7FFF, sat=1.
  - 4 beats of 0x8000×0x7FFF -> dout=0x8000, sat=1.
  - bias=0, beats 0xFFFF×0x0001 then three 0×0 -> dout=0xFFFF (floor), sat=0.
- **ReLU:** bias=0xFF00 (-1.0), all din1=0.
  - RELU=0 -> dout=0xFF00.
  - RELU=1 -> dout=0x0000, sat=0.
- **Reset mid-run:** `reset_n` low after 2 accepted beats -> all outputs 0 and IDLE within the same cycle. A fresh basic run afterwards -> 0x0D00.
- **Back-to-back:** `start` high with `out_ready` on the OUT handshake, second bias=0x0000, same data -> first dout 0x0D00, then ACC with no IDLE cycle, second dout 0x0C00. `start` pulses issued during ACC are ignored.
